// File: rtl/iiitb_rc_arb.sv
// iiitb_rc_arb: round-robin arbiter sharing one resource between N requesters.
// A one-hot ring-counter token marks the highest-priority requester and
// rotates just past each served requester; a hold timer force-releases a
// grantee that keeps the resource for MAX_HOLD consecutive cycles.
//
// Ports:
//   clk     - system clock, all state updates on the rising edge
//   reset   - synchronous active-high reset, overrides every other input
//   init    - token seed, sampled only while reset is high
//   req     - request vector, bit i belongs to requester i
//   done    - release strobe, only the current grantee's bit is honoured
//   gnt     - registered one-hot grant (or zero)
//   token   - registered one-hot priority pointer
//   busy    - registered, high while a grant is held (equals |gnt)
//   timeout - registered one-cycle pulse after a forced release
module iiitb_rc_arb #(
  parameter int unsigned N        = 4,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] init,
  input  logic [N-1:0] req,
  input  logic [N-1:0] done,
  output logic [N-1:0] gnt,
  output logic [N-1:0] token,
  output logic         busy,
  output logic         timeout
);

  // Hold counter counts 0..MAX_HOLD-1 and never wraps.
  localparam int unsigned HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  // Width of a requester index.
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic [N-1:0]    token_q, token_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic            busy_q, busy_d;
  logic            timeout_q, timeout_d;

  logic [N-1:0]    seed;
  logic [IW-1:0]   tok_idx;
  logic [N-1:0]    win_oh;
  logic            win_found;
  logic            vol_rel;
  logic            lim_hit;

  // Token seed: a malformed init falls back to requester 0.
  always_comb begin
    seed = $onehot(init) ? init : N'(1);
  end

  // Index of the current token bit.
  always_comb begin
    tok_idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (token_q[i]) tok_idx = IW'(i);
    end
  end

  // Winner: first set req bit scanning upward from the token, wrapping.
  always_comb begin
    int unsigned   pos_i;
    logic [IW-1:0] pos;
    win_oh    = '0;
    win_found = 1'b0;
    pos_i     = 0;
    pos       = '0;
    for (int unsigned k = 0; k < N; k++) begin
      pos_i = 32'(tok_idx) + k;
      if (pos_i >= N) pos_i = pos_i - N;
      pos = IW'(pos_i);
      if (!win_found && req[pos]) begin
        win_found = 1'b1;
        win_oh    = N'(1) << pos;
      end
    end
  end

  // Release terms for the current grantee; a voluntary release masks timeout.
  always_comb begin
    vol_rel = (|(gnt_q & done)) || ~(|(gnt_q & req));
    lim_hit = (hold_q == HW'(MAX_HOLD - 1));
  end

  // Next-state and output logic.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    token_d   = token_q;
    hold_d    = hold_q;
    busy_d    = busy_q;
    timeout_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d = GRANT;
          gnt_d   = win_oh;
          busy_d  = 1'b1;
          hold_d  = '0;
        end
      end
      GRANT: begin
        if (vol_rel || lim_hit) begin
          state_d   = IDLE;
          gnt_d     = '0;
          busy_d    = 1'b0;
          hold_d    = '0;
          token_d   = {gnt_q[N-2:0], gnt_q[N-1]};
          timeout_d = ~vol_rel;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
        hold_d  = '0;
      end
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      token_q   <= seed;
      hold_q    <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      token_q   <= token_d;
      hold_q    <= hold_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  assign gnt     = gnt_q;
  assign token   = token_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_iiitb_rc_arb.sv
// Self-checking bench for iiitb_rc_arb: directed scenarios plus random
// traffic, each cycle compared against an index-based behavioural model.
module tb_iiitb_rc_arb;

  localparam int unsigned N    = 4;
  localparam int unsigned MAXH = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] init;
  logic [N-1:0] req;
  logic [N-1:0] done;
  logic [N-1:0] gnt;
  logic [N-1:0] token;
  logic         busy;
  logic         timeout;

  int passed = 0;
  int total  = 0;

  // Model state: granted index (-1 = none), token index, hold cycles, timeout.
  int m_g   = -1;
  int m_t   = 0;
  int m_h   = 0;
  bit m_to  = 1'b0;

  iiitb_rc_arb #(.N(N), .MAX_HOLD(MAXH)) dut (
    .clk(clk), .reset(reset), .init(init), .req(req), .done(done),
    .gnt(gnt), .token(token), .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  // Advance the model by one rising edge using the inputs present at that edge.
  task automatic model_step();
    int ones, idx;
    if (reset) begin
      ones = 0; idx = 0;
      for (int i = 0; i < N; i++) if (init[i]) begin ones++; idx = i; end
      m_t  = (ones == 1) ? idx : 0;
      m_g  = -1;
      m_h  = 0;
      m_to = 1'b0;
    end else if (m_g < 0) begin
      m_to = 1'b0;
      for (int k = N - 1; k >= 0; k--)
        if (req[(m_t + k) % N]) m_g = (m_t + k) % N;
      m_h = 0;
    end else begin
      bit vol;
      vol = done[m_g] || !req[m_g];
      if (vol || m_h == MAXH - 1) begin
        m_to = !vol;
        m_t  = (m_g + 1) % N;
        m_g  = -1;
        m_h  = 0;
      end else begin
        m_h++;
        m_to = 1'b0;
      end
    end
  endtask

  // Drive inputs, clock once, then compare every output with the model.
  task automatic cyc(input logic r, input logic [N-1:0] i, input logic [N-1:0] q,
                     input logic [N-1:0] d);
    logic [N-1:0] eg;
    reset = r; init = i; req = q; done = d;
    @(posedge clk);
    model_step();
    #1;
    eg = (m_g < 0) ? '0 : (N'(1) << m_g);
    check("gnt",     gnt,            eg);
    check("token",   token,          N'(1) << m_t);
    check("busy",    N'(busy),       N'(m_g >= 0));
    check("timeout", N'(timeout),    N'(m_to));
    check("gnt_onehot0", N'($onehot0(gnt)), N'(1));
  endtask

  initial begin
    logic [N-1:0] rq;
    reset = 1'b1; init = '0; req = '0; done = '0;

    // Rotation with every requester active and immediate done.
    cyc(1, 4'b0010, 4'b1111, 4'b0000);
    check("seed_0010", token, 4'b0010);
    for (int n = 0; n < 10; n++) cyc(0, 4'b0000, 4'b1111, 4'b1111);

    // Malformed seed, lone requester 3, then done.
    cyc(1, 4'b0110, 4'b0000, 4'b0000);
    check("seed_bad", token, 4'b0001);
    cyc(0, 4'b1111, 4'b1000, 4'b0000);
    check("gnt_req3", gnt, 4'b1000);
    cyc(0, 4'b1111, 4'b1000, 4'b1000);
    check("rel_req3", gnt, 4'b0000);
    check("tok_after3", token, 4'b0001);

    // Forced release after MAX_HOLD cycles, then regrant.
    for (int n = 0; n < 12; n++) cyc(0, 4'b0000, 4'b0100, 4'b0000);
    // Voluntary release coinciding with the limit edge.
    cyc(1, 4'b0100, 4'b0000, 4'b0000);
    cyc(0, 4'b0000, 4'b0100, 4'b0000);
    for (int n = 0; n < MAXH - 1; n++) cyc(0, 4'b0000, 4'b0100, 4'b0000);
    cyc(0, 4'b0000, 4'b0100, 4'b0100);
    check("vol_at_limit_to", N'(timeout), 4'b0000);
    check("vol_at_limit_gnt", gnt, 4'b0000);

    // Foreign done ignored, then req drop releases.
    cyc(1, 4'b0001, 4'b0000, 4'b0000);
    cyc(0, 4'b0000, 4'b0001, 4'b0000);
    cyc(0, 4'b0000, 4'b0101, 4'b0100);
    check("foreign_done", gnt, 4'b0001);
    cyc(0, 4'b0000, 4'b0100, 4'b0000);
    check("drop_tok", token, 4'b0010);

    // Reset mid-grant.
    cyc(1, 4'b1000, 4'b0000, 4'b0000);
    cyc(0, 4'b0000, 4'b1000, 4'b0000);
    cyc(0, 4'b0000, 4'b1000, 4'b0000);
    cyc(1, 4'b0001, 4'b1000, 4'b0000);
    check("midrst_tok", token, 4'b0001);
    for (int n = 0; n < 4; n++) cyc(0, 4'b0000, 4'b1010, 4'b0000);

    // Random traffic with sticky requests, rare done and occasional reset.
    rq = 4'($urandom_range(0, 15));
    for (int n = 0; n < 600; n++) begin
      logic [N-1:0] d;
      if ($urandom_range(0, 7) == 0) rq = 4'($urandom_range(0, 15));
      d = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      cyc(($urandom_range(0, 99) == 0), 4'($urandom_range(0, 15)), rq, d);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
